// File: rtl/comparator_1bit_reg_if.sv
// Bundle of sample and result signals for the registered 1-bit comparator.
// The master drives operands and the clear strobe. The slave returns the flags and counters.
interface comparator_1bit_reg_if #(
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             A;
    logic             B;
    logic             cnt_clr;
    logic             out_valid;
    logic             G;
    logic             L;
    logic             E;
    logic [CNT_W-1:0] g_cnt;
    logic [CNT_W-1:0] l_cnt;
    logic [CNT_W-1:0] e_cnt;

    modport master (
        output in_valid, A, B, cnt_clr,
        input  out_valid, G, L, E, g_cnt, l_cnt, e_cnt
    );

    modport slave (
        input  in_valid, A, B, cnt_clr,
        output out_valid, G, L, E, g_cnt, l_cnt, e_cnt
    );
endinterface

// File: rtl/comparator_1bit_reg.sv
// Registered 1-bit magnitude comparator with saturating G/L/E event counters.
// All outputs come straight from flops, so no input reaches an output combinationally.
module comparator_1bit_reg #(
    parameter int CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    comparator_1bit_reg_if.slave  bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic             g_q, g_d;
    logic             l_q, l_d;
    logic             e_q, e_d;
    logic             out_valid_q, out_valid_d;
    logic [CNT_W-1:0] g_cnt_q, g_cnt_d;
    logic [CNT_W-1:0] l_cnt_q, l_cnt_d;
    logic [CNT_W-1:0] e_cnt_q, e_cnt_d;

    logic             cmp_g, cmp_l, cmp_e;

    // Compare truth table for the current operands.
    always_comb begin
        cmp_g = bus.A & ~bus.B;
        cmp_l = ~bus.A & bus.B;
        cmp_e = ~(bus.A ^ bus.B);
    end

    // Next-state logic for the flags, out_valid and the saturating counters.
    always_comb begin
        // NOTE: every variable gets a default first, so no path can leave one unassigned and infer a latch.
        g_d         = g_q;
        l_d         = l_q;
        e_d         = e_q;
        out_valid_d = 1'b0;
        g_cnt_d     = g_cnt_q;
        l_cnt_d     = l_cnt_q;
        e_cnt_d     = e_cnt_q;

        if (bus.in_valid) begin
            g_d         = cmp_g;
            l_d         = cmp_l;
            e_d         = cmp_e;
            out_valid_d = 1'b1;
        end

        // A clear overrides the increment from the same sample, but the flags still load.
        if (bus.cnt_clr) begin
            g_cnt_d = '0;
            l_cnt_d = '0;
            e_cnt_d = '0;
        end else if (bus.in_valid) begin
            if (cmp_g && g_cnt_q != CNT_MAX) g_cnt_d = g_cnt_q + 1'b1;
            if (cmp_l && l_cnt_q != CNT_MAX) l_cnt_d = l_cnt_q + 1'b1;
            if (cmp_e && e_cnt_q != CNT_MAX) e_cnt_d = e_cnt_q + 1'b1;
        end
    end

    // State register. A synchronous reset overrides every other input.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so that all flops update together on the edge.
        if (rst) begin
            g_q         <= 1'b0;
            l_q         <= 1'b0;
            e_q         <= 1'b0;
            out_valid_q <= 1'b0;
            g_cnt_q     <= '0;
            l_cnt_q     <= '0;
            e_cnt_q     <= '0;
        end else begin
            g_q         <= g_d;
            l_q         <= l_d;
            e_q         <= e_d;
            out_valid_q <= out_valid_d;
            g_cnt_q     <= g_cnt_d;
            l_cnt_q     <= l_cnt_d;
            e_cnt_q     <= e_cnt_d;
        end
    end

    assign bus.G         = g_q;
    assign bus.L         = l_q;
    assign bus.E         = e_q;
    assign bus.out_valid = out_valid_q;
    assign bus.g_cnt     = g_cnt_q;
    assign bus.l_cnt     = l_cnt_q;
    assign bus.e_cnt     = e_cnt_q;
endmodule

// File: tb/tb_comparator_1bit_reg.sv
// Self-checking bench for comparator_1bit_reg. It uses a table of hand-derived vectors on a CNT_W=8 instance.
// Expected values pass through a scoreboard queue.
// A second instance with CNT_W=2 covers counter saturation.
module tb_comparator_1bit_reg;
    logic clk = 1'b0;
    logic rst8;
    logic rst2;

    always #5 clk = ~clk;

    comparator_1bit_reg_if #(.CNT_W(8)) bus8 ();
    comparator_1bit_reg_if #(.CNT_W(2)) bus2 ();

    comparator_1bit_reg #(.CNT_W(8)) dut8 (.clk(clk), .rst(rst8), .bus(bus8));
    comparator_1bit_reg #(.CNT_W(2)) dut2 (.clk(clk), .rst(rst2), .bus(bus2));

    typedef struct {
        string name;
        logic  rst, iv, a, b, clr;
        logic  g, l, e, ov;
        int    gc, lc, ec;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    function automatic vec_t mk(input string name, input logic r, input logic iv, input logic a,
                                input logic b, input logic clr, input logic [3:0] gleo,
                                input int gc, input int lc, input int ec);
        vec_t v;
        v.name = name; v.rst = r; v.iv = iv; v.a = a; v.b = b; v.clr = clr;
        v.g = gleo[3]; v.l = gleo[2]; v.e = gleo[1]; v.ov = gleo[0];
        v.gc = gc; v.lc = lc; v.ec = ec;
        return v;
    endfunction

    // Drive one vector at the falling edge and queue its expectation.
    // Then compare just after the next rising edge.
    task automatic step8(input vec_t v);
        vec_t x;
        @(negedge clk);
        rst8 = v.rst; bus8.in_valid = v.iv; bus8.A = v.a; bus8.B = v.b; bus8.cnt_clr = v.clr;
        sb.push_back(v);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++; failures++;
            $display("FAIL scoreboard_empty: got 0 entries expected 1");
        end else begin
            x = sb.pop_front();
            check({x.name, ".G"},         32'(bus8.G),         32'(x.g));
            check({x.name, ".L"},         32'(bus8.L),         32'(x.l));
            check({x.name, ".E"},         32'(bus8.E),         32'(x.e));
            check({x.name, ".out_valid"}, 32'(bus8.out_valid), 32'(x.ov));
            check({x.name, ".g_cnt"},     32'(bus8.g_cnt),     32'(x.gc));
            check({x.name, ".l_cnt"},     32'(bus8.l_cnt),     32'(x.lc));
            check({x.name, ".e_cnt"},     32'(bus8.e_cnt),     32'(x.ec));
        end
    endtask

    initial begin
        rst8 = 1'b1; rst2 = 1'b1;
        bus8.in_valid = 1'b0; bus8.A = 1'b0; bus8.B = 1'b0; bus8.cnt_clr = 1'b0;
        bus2.in_valid = 1'b0; bus2.A = 1'b0; bus2.B = 1'b0; bus2.cnt_clr = 1'b0;

        // Fields: name, rst, in_valid, A, B, cnt_clr, {G,L,E,out_valid}, g_cnt, l_cnt, e_cnt
        vecs.push_back(mk("reset0",   1, 1, 1, 0, 0, 4'b0000, 0, 0, 0));
        vecs.push_back(mk("reset1",   1, 1, 1, 0, 0, 4'b0000, 0, 0, 0));
        vecs.push_back(mk("tt_01",    0, 1, 0, 1, 0, 4'b0101, 0, 1, 0));
        vecs.push_back(mk("tt_11",    0, 1, 1, 1, 0, 4'b0011, 0, 1, 1));
        vecs.push_back(mk("tt_10",    0, 1, 1, 0, 0, 4'b1001, 1, 1, 1));
        vecs.push_back(mk("tt_00",    0, 1, 0, 0, 0, 4'b0011, 1, 1, 2));
        vecs.push_back(mk("g_again",  0, 1, 1, 0, 0, 4'b1001, 2, 1, 2));
        vecs.push_back(mk("hold0",    0, 0, 0, 1, 0, 4'b1000, 2, 1, 2));
        vecs.push_back(mk("hold1",    0, 0, 1, 1, 0, 4'b1000, 2, 1, 2));
        vecs.push_back(mk("hold2",    0, 0, 0, 0, 0, 4'b1000, 2, 1, 2));
        vecs.push_back(mk("l_to_2",   0, 1, 0, 1, 0, 4'b0101, 2, 2, 2));
        vecs.push_back(mk("clr_prio", 0, 1, 0, 1, 1, 4'b0101, 0, 0, 0));
        vecs.push_back(mk("post_clr", 0, 1, 0, 1, 0, 4'b0101, 0, 1, 0));
        vecs.push_back(mk("l_2b",     0, 1, 0, 1, 0, 4'b0101, 0, 2, 0));
        vecs.push_back(mk("clr_idle", 0, 0, 1, 0, 1, 4'b0100, 0, 0, 0));
        vecs.push_back(mk("l_1c",     0, 1, 0, 1, 0, 4'b0101, 0, 1, 0));
        vecs.push_back(mk("rst_mid",  1, 1, 0, 1, 0, 4'b0000, 0, 0, 0));
        vecs.push_back(mk("after_rst",0, 1, 1, 1, 0, 4'b0011, 0, 0, 1));
        vecs.push_back(mk("idle_end", 0, 0, 1, 0, 0, 4'b0010, 0, 0, 1));

        for (int i = 0; i < vecs.size(); i++) step8(vecs[i]);

        // Saturation on the 2-bit instance: e_cnt must run 1, 2, 3, 3, 3.
        @(negedge clk);
        rst2 = 1'b1; bus2.in_valid = 1'b1; bus2.A = 1'b1; bus2.B = 1'b1;
        @(posedge clk); #1;
        check("sat.reset_e_cnt", 32'(bus2.e_cnt), 32'd0);
        check("sat.reset_E",     32'(bus2.E),     32'd0);
        for (int i = 0; i < 5; i++) begin
            int exp_e;
            exp_e = (i + 1 > 3) ? 3 : i + 1;
            @(negedge clk);
            rst2 = 1'b0; bus2.in_valid = 1'b1; bus2.A = 1'b1; bus2.B = 1'b1;
            @(posedge clk); #1;
            check($sformatf("sat.e_cnt[%0d]", i), 32'(bus2.e_cnt), 32'(exp_e));
            check($sformatf("sat.E[%0d]", i),     32'(bus2.E),     32'd1);
            check($sformatf("sat.g_cnt[%0d]", i), 32'(bus2.g_cnt), 32'd0);
        end
        // A saturated counter must still clear.
        @(negedge clk);
        bus2.cnt_clr = 1'b1;
        @(posedge clk); #1;
        check("sat.clr_e_cnt", 32'(bus2.e_cnt), 32'd0);
        check("sat.clr_E",     32'(bus2.E),     32'd1);
        @(negedge clk);
        bus2.cnt_clr = 1'b0; bus2.in_valid = 1'b0;

        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/comparator_1bit_reg.md
# comparator_1bit_reg

Registered 1-bit magnitude comparator with per-result event counters. It compares two single-bit operands A and B and produces mutually exclusive greater/less/equal flags. Each flag has a saturating occurrence counter for status reporting. The block is a leaf primitive for control paths that need a clocked compare result plus simple statistics.

## Interface
- CNT_W, default 8: width of each event counter (legal range 1–32).
- clk  input  1  sole clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  A/B sample is valid this cycle.
- A  input  1  operand A.
- B  input  1  operand B.
- cnt_clr  input  1  synchronous clear of all three counters.
- out_valid  output  1  G/L/E updated from a valid sample on the previous edge.
- G  output  1  A > B (A=1, B=0).
- L  output  1  A < B (A=0, B=1).
- E  output  1  A == B.
- g_cnt  output  CNT_W  count of accepted samples with A > B.
- l_cnt  output  CNT_W  count of accepted samples with A < B.
- e_cnt  output  CNT_W  count of accepted samples with A == B.

## Operation
- Compare truth table:
  - A=0, B=0 gives G=0, L=0, E=1.
  - A=0, B=1 gives G=0, L=1, E=0.
  - A=1, B=0 gives G=1, L=0, E=0.
  - A=1, B=1 gives G=0, L=0, E=1.
- A sample is accepted on a rising edge when in_valid=1 and rst=0.
  - G/L/E are loaded from the table.
  - out_valid is set to 1.
  - The matching counter increments by 1.
- No accepted sample (in_valid=0):
  - G/L/E hold their previous values.
  - out_valid goes to 0.
  - Counters hold.
- After the first accepted sample, exactly one of G/L/E is 1 at all times until the next reset.
- Counters saturate at 2^CNT_W−1 and never wrap.
- cnt_clr=1 zeroes all three counters on that edge.
  - cnt_clr has priority over a simultaneous increment; that sample's count is discarded.
  - cnt_clr does not affect G/L/E or out_valid, so the compare result still loads.
- X/Z on A or B while in_valid=1 is illegal input; the outputs are unspecified in that case.

## Timing
- Reset, synchronous: G=0, L=0, E=0, out_valid=0, g_cnt=l_cnt=e_cnt=0. This is the only state in which all three flags are 0.
- rst has priority over in_valid and cnt_clr.
- Reset asserted mid-stream discards the sample on that edge.
- Latency: 1 cycle from an accepted sample to G/L/E/out_valid.
- Counters reflect a sample on the same edge that G/L/E update.
- Throughput: one sample per cycle; back-to-back valid samples all count.
- No combinational path from inputs to outputs.

## Test plan
- Reset behaviour:
  - Stimulus: assert rst for 2 cycles with in_valid=1, A=1, B=0.
  - Required: G=L=E=0, out_valid=0, all counters 0.
- Full truth table:
  - Stimulus: valid samples (A,B) = (0,1), (1,1), (1,0), (0,0) on consecutive cycles.
  - Required, one cycle later each: (G,L,E) = 010, 001, 100, 001 with out_valid=1.
  - Required final counts: g_cnt=1, l_cnt=1, e_cnt=2.
- Hold:
  - Stimulus: after (1,0) is accepted, drop in_valid for 3 cycles and toggle A/B.
  - Required: G=1, L=0, E=0 hold; out_valid=0; counters unchanged.
- Saturation:
  - Stimulus: CNT_W=2, five consecutive valid (1,1) samples.
  - Required: e_cnt goes 1, 2, 3, 3, 3.
- Clear priority:
  - Stimulus: cnt_clr=1 together with a valid (0,1) sample when l_cnt=2.
  - Required: l_cnt=0 next cycle; L=1 and out_valid=1 still update.
- Reset mid-stream:
  - Stimulus: rst with in_valid=1, A=0, B=1 after several samples.
  - Required: all outputs return to reset values; l_cnt does not increment.
